seq_product_divider: RTL and testbench
======================================

# seq_product_divider

Sequential restoring divider that inverts the 5x5 Wallace-tree multiplier: it takes a 10-bit product-width dividend and a 5-bit operand-width divisor and returns a 10-bit quotient and a 5-bit remainder. Operands enter and results leave over independent valid/ready handshakes. It produces one quotient bit per clock. It sits beside the multiplier datapath and serves as the round-trip checker: (a*b)/b == a, remainder 0.

## Interface
- DIVIDEND_W, 10, dividend and quotient width (multiplier product width)
- DIVISOR_W, 5, divisor and remainder width (multiplier operand width)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present on dividend/divisor
- in_ready  output  1  block accepts operands
- dividend  input  DIVIDEND_W  numerator, unsigned
- divisor  input  DIVISOR_W  denominator, unsigned
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- quotient  output  DIVIDEND_W  floor(dividend/divisor)
- remainder  output  DIVISOR_W  dividend mod divisor
- div_by_zero  output  1  divisor was 0 for this result

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - An input transfer occurs on in_valid && in_ready at a rising edge. It captures dividend into the shift register and divisor into a hold register.
  - It also clears the partial remainder (DIVISOR_W+1 = 6 bits) and the quotient, and loads the step counter with DIVIDEND_W-1.
  - Divisor != 0: go to RUN.
  - Divisor == 0: go to DONE with quotient=all ones (10'h3FF), remainder=0, div_by_zero=1.
- RUN, one restoring step per cycle:
  - Shift the dividend MSB into the partial remainder (pr = {pr[4:0], msb}).
  - If pr >= divisor: pr -= divisor and quotient bit=1; otherwise quotient bit=0.
  - Shift the quotient bit into the quotient LSB.
  - When the counter reaches 0, go to DONE.
- Width rules:
  - The shifted partial remainder never exceeds 2*divisor-1 = 61, so 6 bits suffice.
  - The final remainder is < divisor and fits in DIVISOR_W bits; the top pr bit is dropped.
- DONE
  - out_valid=1. quotient, remainder and div_by_zero are held stable while out_valid && !out_ready.
  - An output transfer occurs on out_valid && out_ready; the block then returns to IDLE.
- in_ready=0 in RUN and DONE.
  - Inputs are ignored there; in_valid stays pending upstream.
  - No accept happens in the same cycle as the output transfer.
- div_by_zero=0 for every nonzero divisor.

## Timing
- Reset (async assert, sync release) drives:
  - state=IDLE, in_ready=1, out_valid=0;
  - quotient=0, remainder=0, div_by_zero=0;
  - counter=0.
- Reset mid-RUN or mid-DONE drops the in-flight operation; no result is emitted.
- Latency, input transfer at edge T:
  - nonzero divisor: out_valid high after edge T+10 (DIVIDEND_W steps);
  - zero divisor: out_valid high after edge T+1.
- With out_ready held 1, out_valid lasts one cycle and in_ready is high the cycle after.
  - Minimum initiation interval: 12 cycles for nonzero divisors, 3 for zero.
- in_ready and out_valid are pure state decodes (registered, no combinational path from inputs).

## Structure
- Package seq_divider_pkg:
  - DIVIDEND_W/DIVISOR_W default constants;
  - state typedef enum logic [1:0] {IDLE, RUN, DONE};
  - counter width localparam $clog2(DIVIDEND_W).
- One sub-module, restoring_div_step, purely combinational:
  - inputs: pr, incoming bit, divisor;
  - outputs: next pr and quotient bit;
  - uses an explicit subtract-and-borrow compare.
- Top module holds the FSM, counter, shift registers and handshake.

## Test plan
- 15/3, 961/31, 750/25 back-to-back with out_ready=1:
  - results q=5/31/30, r=0 each, div_by_zero=0;
  - each result 10 cycles after its accept.
- 1000/7 -> q=142, r=6. 1023/1 -> q=1023, r=0. 4/31 -> q=0, r=4.
- 200/0 -> q=10'h3FF, r=0, div_by_zero=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles after 200/20 completes, with in_valid=1 and new operands applied throughout.
  - q=10, r=0 stay stable; in_ready stays 0; the new operands are accepted only after the output transfer plus one IDLE cycle.
- Reset: pull rst_n low in cycle 5 of RUN.
  - All outputs go to reset values immediately; in_ready=1 after release; no stale out_valid.
  - A following 961/31 returns q=31, r=0.
- Round trip: for all a,b in 0..31 with b!=0, feed the multiplier product a*b as the dividend and b as the divisor -> q=a, r=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential product divider.
package seq_divider_pkg;
  localparam int DEF_DIVIDEND_W = 10;
  localparam int DEF_DIVISOR_W  = 5;
  localparam int CNT_W          = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module restoring_div_step
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   pr_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_out,
  output logic                 q_bit
);
  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] diff;
  logic                 borrow;
  logic                 unused_pr_msb;

  // pr entering a step is always below the divisor, so its top bit is zero
  assign unused_pr_msb = pr_in[DIVISOR_W];

  assign shifted = {pr_in[DIVISOR_W-1:0], bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = diff[DIVISOR_W+1];
  assign q_bit   = ~borrow;
  assign pr_out  = borrow ? shifted : diff[DIVISOR_W:0];
endmodule

// File: rtl/seq_product_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one restoring step per cycle (a single pass for a zero divisor)
//   DONE  | result held, out_valid=1 until out_ready
module seq_product_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(DIVIDEND_W);

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    pr, pr_nx;
  logic [DIVIDEND_W-1:0] quo;
  logic                  dbz;
  logic                  q_bit;

  restoring_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .pr_in   (pr),
    .bit_in  (dvd_sr[DIVIDEND_W-1]),
    .divisor (dvs),
    .pr_out  (pr_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)      state_nx = RUN;
      RUN:     if (cnt == '0)     state_nx = DONE;
      DONE:    if (out_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // A zero divisor still takes one RUN cycle, which gives it a one-edge latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dvd_sr <= '0;
      dvs    <= '0;
      pr     <= '0;
      quo    <= '0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd_sr <= dividend;
          dvs    <= divisor;
          pr     <= '0;
          quo    <= '0;
          dbz    <= 1'b0;
          cnt    <= (divisor == '0) ? '0 : CW'(DIVIDEND_W - 1);
        end
        RUN: if (dvs == '0) begin
          quo <= '1;
          pr  <= '0;
          dbz <= 1'b1;
        end else begin
          pr     <= pr_nx;
          quo    <= {quo[DIVIDEND_W-2:0], q_bit};
          dvd_sr <= dvd_sr << 1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo;
  assign remainder   = pr[DIVISOR_W-1:0];
  assign div_by_zero = dbz;
endmodule

// File: tb/tb_seq_product_divider.sv
// Randomized and directed bench for seq_product_divider against an arithmetic reference.
module tb_seq_product_divider;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_product_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? 1023 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? 0 : a % b;
  endfunction

  // Called at a negedge; returns at the negedge after the output transfer.
  task automatic run_op(input int a_in, input int b_in);
    int a, b, guard, lat;
    a = a_in & 10'h3FF;
    b = b_in & 5'h1F;
    in_valid  = 1'b1;
    dividend  = a[9:0];
    divisor   = b[4:0];
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", 32'(guard < 50), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (b == 0) ? 1 : 10);
    chk("quotient", quotient, ref_q(a, b));
    chk("remainder", remainder, ref_r(a, b));
    chk("div_by_zero", div_by_zero, 32'(b == 0));
    @(negedge clk);
    chk("out_valid_one_cycle", out_valid, 0);
    chk("in_ready_after_xfer", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen_valid;

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(15, 3);
    run_op(961, 31);
    run_op(750, 25);
    run_op(1000, 7);
    run_op(1023, 1);
    run_op(4, 31);
    run_op(200, 0);

    // Backpressure: 200/20 held while new operands sit on the inputs
    in_valid  = 1'b1;
    dividend  = 10'd200;
    divisor   = 5'd20;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dividend = 10'd77;
    divisor  = 5'd5;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_quotient", quotient, 10);
      chk("bp_remainder", remainder, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_next_latency", lat, 10);
    chk("bp_next_quotient", quotient, 77 / 5);
    chk("bp_next_remainder", remainder, 77 % 5);
    @(negedge clk);

    // Reset in the middle of RUN
    in_valid = 1'b1;
    dividend = 10'd961;
    divisor  = 5'd31;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("no_stale_out_valid", seen_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    run_op(961, 31);

    // Multiplier round trip
    for (int a = 0; a < 32; a++)
      for (int b = 1; b < 32; b++)
        run_op(a * b, b);

    for (int i = 0; i < 300; i++)
      run_op(int'($urandom_range(1023, 0)), int'($urandom_range(31, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
